coin_acceptor: RTL

Upstream front end of the coffee machine. Debounces the two raw coin push-buttons and converts each confirmed press into one coin event. Accumulates credit in units of 100 (a 500 coin adds 5) and serves a price-deduct handshake to the selector/brew stage. Also handles a user refund, and rejects coins that would overflow the 4-bit credit.

---
 rtl/coin_acceptor_pkg.sv | 22 ++
 rtl/coin_acceptor_debouncer.sv | 89 ++++++++
 rtl/coin_acceptor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared types and constants for the coin acceptor slice.
package coin_acceptor_pkg;

   localparam int CREDIT_W = 4;
   localparam logic [CREDIT_W-1:0] COIN_100_UNITS = 4'd1;
   localparam logic [CREDIT_W-1:0] COIN_500_UNITS = 4'd5;

   typedef logic [CREDIT_W-1:0] credit_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      PRESSED   = 2'd2,
      DISARMING = 2'd3
   } debounce_state_t;

   // True when adding units to base stays within limit (computed one bit wider).
   function automatic logic coin_fits(credit_t base, credit_t units, credit_t limit);
      return (({1'b0, base} + {1'b0, units}) <= {1'b0, limit});
   endfunction

endpackage

// File: rtl/coin_acceptor_debouncer.sv
// Button debouncer: 2-flop synchronizer, polarity normalisation, press/release FSM.
module button_debouncer
   import coin_acceptor_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 1000000,
   parameter logic ACTIVE_LOW      = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [1:0] ST_IDLE      = 2'(IDLE);
   localparam logic [1:0] ST_ARMING    = 2'(ARMING);
   localparam logic [1:0] ST_PRESSED   = 2'(PRESSED);
   localparam logic [1:0] ST_DISARMING = 2'(DISARMING);
   localparam logic [1:0] SYNC_IDLE    = ACTIVE_LOW ? 2'b11 : 2'b00;

   logic [1:0]       sync_r;
   logic [1:0]       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
   logic             pulse_r, pulse_s, pressed_s;

   assign pressed_s = ACTIVE_LOW ? ~sync_r[1] : sync_r[1];
   assign pulse     = pulse_r;

   // Next-state logic; the count restarts at 1 on entry to a counting state.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pulse_s = 1'b0;
      if ((state_r == ST_IDLE) || (state_r == ST_PRESSED)) begin
         cnt_inc_s = CNT_ONE;
      end else begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end
      case (state_r)
         ST_IDLE, ST_ARMING: begin
            if (!pressed_s) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else if (cnt_inc_s >= CNT_LIM) begin
               state_s = ST_PRESSED;
               cnt_s   = '0;
               pulse_s = 1'b1;
            end else begin
               state_s = ST_ARMING;
               cnt_s   = cnt_inc_s;
            end
         end
         ST_PRESSED, ST_DISARMING: begin
            if (pressed_s) begin
               state_s = ST_PRESSED;
               cnt_s   = '0;
            end else if (cnt_inc_s >= CNT_LIM) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else begin
               state_s = ST_DISARMING;
               cnt_s   = cnt_inc_s;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Synchronizer and FSM registers; reset parks the synchronizer at the released level.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_r  <= SYNC_IDLE;
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         pulse_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], raw};
         state_r <= state_s;
         cnt_r   <= cnt_s;
         pulse_r <= pulse_s;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: debounced coin events, credit register, deduct/refund handshake.
// Optional inactivity auto-refund is enabled by defining COIN_ACCEPTOR_AUTO_REFUND_EN.
module coin_acceptor
   import coin_acceptor_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES   = 1000000,
   parameter int   CREDIT_MAX        = 15,
   parameter logic BUTTON_ACTIVE_LOW = 1'b1,
   parameter int   TIMEOUT_CYCLES    = 500000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_100,
   input  logic       coin_500,
   input  logic       refund,
   input  logic [3:0] price,
   input  logic       deduct_req,
   output logic       deduct_ack,
   output logic       insufficient,
   output logic [3:0] credit,
   output logic       credit_full,
   output logic       coin_rejected,
   output logic       refund_valid,
   output logic [3:0] refund_amount
);

   localparam credit_t CREDIT_LIM = CREDIT_W'(CREDIT_MAX);

   logic    ev_100_s, ev_500_s, refund_q_r, refund_s, auto_refund_s;
   logic    ack_s, insuf_s, rej_s, refv_s;
   credit_t base_s, sum_500_s, sum_s, ramt_s;
   credit_t credit_r, ramt_r;
   logic    ack_r, insuf_r, rej_r, refv_r, full_r;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BUTTON_ACTIVE_LOW))
      u_deb_100 (.clock(clock), .reset(reset), .raw(coin_100), .pulse(ev_100_s));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BUTTON_ACTIVE_LOW))
      u_deb_500 (.clock(clock), .reset(reset), .raw(coin_500), .pulse(ev_500_s));

   assign refund_s = (refund & ~refund_q_r) | auto_refund_s;

   // Priority: refund, then deduct, then coins applied on top (500 before 100).
   always_comb begin
      base_s  = credit_r;
      ramt_s  = ramt_r;
      ack_s   = 1'b0;
      insuf_s = 1'b0;
      refv_s  = 1'b0;
      rej_s   = 1'b0;
      if (refund_s) begin
         base_s = '0;
         ramt_s = credit_r;
         refv_s = 1'b1;
      end else if (deduct_req) begin
         if (credit_r >= price) begin
            base_s = credit_r - price;
            ack_s  = 1'b1;
         end else begin
            insuf_s = 1'b1;
         end
      end else begin
         base_s = credit_r;
      end
      sum_500_s = base_s;
      if (ev_500_s) begin
         if (coin_fits(base_s, COIN_500_UNITS, CREDIT_LIM)) begin
            sum_500_s = base_s + COIN_500_UNITS;
         end else begin
            rej_s = 1'b1;
         end
      end else begin
         sum_500_s = base_s;
      end
      sum_s = sum_500_s;
      if (ev_100_s) begin
         if (coin_fits(sum_500_s, COIN_100_UNITS, CREDIT_LIM)) begin
            sum_s = sum_500_s + COIN_100_UNITS;
         end else begin
            rej_s = 1'b1;
         end
      end else begin
         sum_s = sum_500_s;
      end
   end

`ifdef COIN_ACCEPTOR_AUTO_REFUND_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_r;

   assign auto_refund_s = (tmo_r == TMO_W'(TIMEOUT_CYCLES)) && (credit_r != '0);

   // Inactivity counter, held at zero while there is no credit.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_r <= '0;
      end else if ((credit_r == '0) || ev_100_s || ev_500_s || ack_s || refund_s) begin
         tmo_r <= '0;
      end else begin
         tmo_r <= tmo_r + TMO_W'(1);
      end
   end
`else
   assign auto_refund_s = 1'b0;
`endif

   // Registered credit state and one-cycle response pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         credit_r   <= '0;
         ramt_r     <= '0;
         refund_q_r <= 1'b0;
         ack_r      <= 1'b0;
         insuf_r    <= 1'b0;
         rej_r      <= 1'b0;
         refv_r     <= 1'b0;
         full_r     <= 1'b0;
      end else begin
         credit_r   <= sum_s;
         ramt_r     <= ramt_s;
         refund_q_r <= refund;
         ack_r      <= ack_s;
         insuf_r    <= insuf_s;
         rej_r      <= rej_s;
         refv_r     <= refv_s;
         full_r     <= (sum_s == CREDIT_LIM);
      end
   end

   assign credit        = credit_r;
   assign refund_amount = ramt_r;
   assign deduct_ack    = ack_r;
   assign insufficient  = insuf_r;
   assign coin_rejected = rej_r;
   assign refund_valid  = refv_r;
   assign credit_full   = full_r;

endmodule
